// File: rtl/mdu_seq_pkg.sv
// Shared types for the multiply/divide sequencer: operation encoding,
// machine word, and iteration counter width.
package pipes;

  localparam int MDU_WIDTH = 64;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

  typedef logic [MDU_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    MDU_MUL  = 3'd0,
    MDU_DIV  = 3'd1,
    MDU_DIVU = 3'd2,
    MDU_REM  = 3'd3,
    MDU_REMU = 3'd4
  } mdu_op_t;

  function automatic logic mdu_is_signed_div(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic mdu_is_rem(mdu_op_t op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/mdu_seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // One extra bit keeps the compare exact for unsigned divisors above 2^(WIDTH-1).
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, msb_i};
  assign qbit_o  = (shifted >= {1'b0, divisor_i});
  assign diff    = shifted[WIDTH-1:0] - divisor_i;
  assign rem_o   = qbit_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, with RISC-V divide-by-zero and overflow short-circuits.
module mdu_seq
  import pipes::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [WIDTH-1:0]     MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MDU_CNT_W-1:0] CNT_INIT = MDU_CNT_W'(WIDTH);
  localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(1);

  state_t               state_q, state_d;
  mdu_op_t              op_q, op_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, rem_q, rem_d, res_q, res_d;
  logic                 negq_q, negq_d, negr_q, negr_d;

  logic             s1_neg, s2_neg, ovf;
  logic [WIDTH-1:0] step_rem, quot_nx, mul_nx, q_fixed, r_fixed;
  logic             step_qbit;

  // a_q holds multiplicand/dividend, b_q multiplier/divisor, acc_q product/quotient.
  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (a_q[WIDTH-1]),
    .divisor_i (b_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  assign s1_neg  = mdu_is_signed_div(op) && src1[WIDTH-1];
  assign s2_neg  = mdu_is_signed_div(op) && src2[WIDTH-1];
  assign ovf     = mdu_is_signed_div(op) && (src1 == MIN_NEG) && (&src2);
  assign quot_nx = {acc_q[WIDTH-2:0], step_qbit};
  assign mul_nx  = b_q[0] ? (acc_q + a_q) : acc_q;
  assign q_fixed = negq_q ? -quot_nx : quot_nx;
  assign r_fixed = negr_q ? -step_rem : step_rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op_d = op;
          if (op == MDU_MUL) begin
            a_d     = src1;
            b_d     = src2;
            acc_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = MUL_RUN;
          end else if (src2 == '0) begin
            res_d   = mdu_is_rem(op) ? src1 : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = mdu_is_rem(op) ? '0 : src1;
            state_d = DONE;
          end else begin
            a_d     = s1_neg ? -src1 : src1;
            b_d     = s2_neg ? -src2 : src2;
            acc_d   = '0;
            rem_d   = '0;
            negq_d  = s1_neg ^ s2_neg;
            negr_d  = s1_neg;
            cnt_d   = CNT_INIT;
            state_d = DIV_RUN;
          end
        end
        MUL_RUN: begin
          acc_d = mul_nx;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_d   = mul_nx;
            state_d = DONE;
          end
        end
        DIV_RUN: begin
          rem_d = step_rem;
          a_d   = a_q << 1;
          acc_d = quot_nx;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_d   = mdu_is_rem(op_q) ? r_fixed : q_fixed;
            state_d = DONE;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= MDU_MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mdu_seq;
  import pipes::*;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  mdu_op_t     op = MDU_MUL;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(mdu_op_t o, logic [63:0] a, logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    case (o)
      MDU_MUL:  return a * b;
      MDU_DIVU: return (b == 0) ? ALL1 : a / b;
      MDU_REMU: return (b == 0) ? a : a % b;
      MDU_DIV:  begin
        if (b == 0) return ALL1;
        if (a == MIN_NEG && b == ALL1) return a;
        return sa / sb;
      end
      MDU_REM:  begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == ALL1) return 64'd0;
        return sa % sb;
      end
      default:  return 64'hx;
    endcase
  endfunction

  function automatic int ref_lat(mdu_op_t o, logic [63:0] a, logic [63:0] b);
    if (o == MDU_MUL) return 65;
    if (b == 0) return 1;
    if ((o == MDU_DIV || o == MDU_REM) && a == MIN_NEG && b == ALL1) return 1;
    return 65;
  endfunction

  // Issue one request and wait for out_valid; lat counts edges from the accept edge.
  task automatic issue(input mdu_op_t o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input mdu_op_t o, input logic [63:0] a,
                           input logic [63:0] b);
    logic [63:0] res;
    int lat;
    issue(o, a, b, res, lat);
    check({tag, "_res"}, res, ref_mdu(o, a, b));
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(o, a, b)));
    release_result();
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] res, held, a, b;
    int lat;
    mdu_op_t o;

    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_check("mul_7x6", MDU_MUL, 64'd7, 64'd6);
    run_check("mul_ffx2", MDU_MUL, ALL1, 64'd2);
    run_check("div_m20_3", MDU_DIV, -64'sd20, 64'd3);
    run_check("rem_m20_3", MDU_REM, -64'sd20, 64'd3);
    run_check("divu_100_7", MDU_DIVU, 64'd100, 64'd7);
    run_check("remu_100_7", MDU_REMU, 64'd100, 64'd7);
    run_check("divu_5_0", MDU_DIVU, 64'd5, 64'd0);
    run_check("rem_5_0", MDU_REM, 64'd5, 64'd0);
    run_check("div_ovf", MDU_DIV, MIN_NEG, ALL1);
    run_check("rem_ovf", MDU_REM, MIN_NEG, ALL1);
    run_check("divu_big", MDU_DIVU, ALL1, 64'hC000_0000_0000_0001);

    // Backpressure: result must hold while the consumer stalls.
    issue(MDU_MUL, 64'd12345, 64'd1000, held, lat);
    check("bp_first", held, 64'd12345000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result", result, held);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    release_result();
    check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
    check("bp_out_valid_after", {63'd0, out_valid}, 64'd0);

    // Flush at iteration 30 of a divide.
    @(negedge clk);
    op = MDU_DIV; src1 = 64'd1_000_000; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (70) @(posedge clk);
    #1;
    check("flush_stays_idle", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    op = MDU_MUL; src1 = 64'd99; src2 = 64'd99; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_check("mul_3x3", MDU_MUL, 64'd3, 64'd3);

    for (int k = 0; k < 40; k++) begin
      o = mdu_op_t'($urandom_range(0, 4));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin a = MIN_NEG; b = ALL1; end
        2: b = 64'($urandom_range(1, 20));
        3: begin a = 64'($urandom_range(0, 1000)); b = -64'($urandom_range(1, 30)); end
        default: ;
      endcase
      issue(o, a, b, res, lat);
      check($sformatf("rnd%0d_%s_res", k, o.name()), res, ref_mdu(o, a, b));
      check($sformatf("rnd%0d_%s_lat", k, o.name()), 64'(lat), 64'(ref_lat(o, a, b)));
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
